// File: rtl/max4_pool_unit_if.sv
// Window/result bundle for max4_pool_unit: four samples plus valid in, max, winner index and valid out.
// master = pooling line buffer / controller side, slave = the selector.
interface max4_pool_unit_if #(
  parameter int W = 9
);
  logic         in_valid;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] in3;
  logic [W-1:0] dout;
  logic [1:0]   max_idx;
  logic         out_valid;

  modport master (
    output in_valid, in0, in1, in2, in3,
    input  dout, max_idx, out_valid
  );

  modport slave (
    input  in_valid, in0, in1, in2, in3,
    output dout, max_idx, out_valid
  );
endinterface

// File: rtl/max4_pool_unit.sv
// 2x2 max-pool selector: registered max of four samples plus winning index (lowest index wins ties).
// Latency 1 cycle, or 2 cycles with MAX4A_PIPE_EN defined (stage A registered); 1 window per clock.
// No backpressure: a window is accepted every cycle in_valid is high; outputs hold when idle.
module max4_pool_unit #(
  parameter int W      = 9,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  max4_pool_unit_if.slave  bus
);

  // Strictly greater only, so equal values leave the lower-indexed operand in place.
  function automatic logic b_wins(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED != 0) return $signed(b) > $signed(a);
    else             return b > a;
  endfunction

  logic [W-1:0] m01, m23;
  logic [1:0]   idx01, idx23;
  logic [W-1:0] b_m01, b_m23;
  logic [1:0]   b_idx01, b_idx23;
  logic         b_valid;
  logic [W-1:0] res;
  logic [1:0]   res_idx;
  logic [W-1:0] dout_q;
  logic [1:0]   max_idx_q;
  logic         out_valid_q;

  always_comb begin
    m01   = bus.in0;
    idx01 = 2'd0;
    if (b_wins(bus.in0, bus.in1)) begin
      m01   = bus.in1;
      idx01 = 2'd1;
    end
    m23   = bus.in2;
    idx23 = 2'd2;
    if (b_wins(bus.in2, bus.in3)) begin
      m23   = bus.in3;
      idx23 = 2'd3;
    end
  end

`ifdef MAX4A_PIPE_EN
  logic [W-1:0] m01_q, m23_q;
  logic [1:0]   idx01_q, idx23_q;
  logic         a_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      m01_q     <= '0;
      m23_q     <= '0;
      idx01_q   <= 2'd0;
      idx23_q   <= 2'd0;
      a_valid_q <= 1'b0;
    end else begin
      a_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        m01_q   <= m01;
        m23_q   <= m23;
        idx01_q <= idx01;
        idx23_q <= idx23;
      end
    end
  end

  assign b_m01   = m01_q;
  assign b_m23   = m23_q;
  assign b_idx01 = idx01_q;
  assign b_idx23 = idx23_q;
  assign b_valid = a_valid_q;
`else
  assign b_m01   = m01;
  assign b_m23   = m23;
  assign b_idx01 = idx01;
  assign b_idx23 = idx23;
  assign b_valid = bus.in_valid;
`endif

  always_comb begin
    res     = b_m01;
    res_idx = b_idx01;
    if (b_wins(b_m01, b_m23)) begin
      res     = b_m23;
      res_idx = b_idx23;
    end
  end

  // Capture only on valid so undriven samples between windows never reach dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q      <= '0;
      max_idx_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= b_valid;
      if (b_valid) begin
        dout_q    <= res;
        max_idx_q <= res_idx;
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.max_idx   = max_idx_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_max4_pool_unit.sv
// Bench for max4_pool_unit: signed and unsigned instances share stimulus; a scoreboard
// queue holds expected max/index and the cycle each result is due.
module tb_max4_pool_unit;

  localparam int W = 9;
`ifdef MAX4A_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [W-1:0] sd;
    logic [1:0]   si;
    logic [W-1:0] ud;
    logic [1:0]   ui;
    int unsigned  due;
  } exp_t;

  logic clk;
  logic rst;
  int unsigned cyc = 0;
  bit   rst_seen = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vld_cnt = 0;
  logic [W-1:0] hold_sd = '0, hold_ud = '0;
  logic [1:0]   hold_si = '0, hold_ui = '0;
  exp_t sbq[$];

  max4_pool_unit_if #(.W(W)) ifs ();
  max4_pool_unit_if #(.W(W)) ifu ();

  max4_pool_unit #(.W(W), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));
  max4_pool_unit #(.W(W), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(ifu.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit gt(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    return sgn ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  // Expected winner is the first occurrence of the maximum.
  function automatic logic [1:0] ref_idx(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [W-1:0] d,
                                         input bit sgn);
    logic [W-1:0] v [4];
    int best;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    best = 0;
    for (int i = 1; i < 4; i++)
      if (gt(v[i], v[best], sgn)) best = i;
    return 2'(best);
  endfunction

  task automatic monitor();
    exp_t e;
    if (rst_seen) begin
      chk("rst_s_vld", 32'(ifs.out_valid), 0);
      chk("rst_s_dout", 32'(ifs.dout), 0);
      chk("rst_s_idx", 32'(ifs.max_idx), 0);
      chk("rst_u_vld", 32'(ifu.out_valid), 0);
      chk("rst_u_dout", 32'(ifu.dout), 0);
      chk("rst_u_idx", 32'(ifu.max_idx), 0);
      sbq.delete();
      hold_sd = '0; hold_si = '0; hold_ud = '0; hold_ui = '0;
    end else if (ifs.out_valid === 1'b1) begin
      chk("u_vld_align", 32'(ifu.out_valid), 1);
      if (sbq.size() == 0) begin
        chk("spurious_vld", 32'(ifs.out_valid), 0);
      end else begin
        e = sbq.pop_front();
        chk("latency", cyc, e.due);
        chk("s_dout", 32'(ifs.dout), 32'(e.sd));
        chk("s_idx", 32'(ifs.max_idx), 32'(e.si));
        chk("u_dout", 32'(ifu.dout), 32'(e.ud));
        chk("u_idx", 32'(ifu.max_idx), 32'(e.ui));
        hold_sd = e.sd; hold_si = e.si; hold_ud = e.ud; hold_ui = e.ui;
        vld_cnt++;
      end
    end else begin
      chk("u_vld_idle", 32'(ifu.out_valid), 0);
      chk("s_hold", 32'(ifs.dout), 32'(hold_sd));
      chk("s_idx_hold", 32'(ifs.max_idx), 32'(hold_si));
      chk("u_hold", 32'(ifu.dout), 32'(hold_ud));
      chk("u_idx_hold", 32'(ifu.max_idx), 32'(hold_ui));
    end
  endtask

  // One clock: the DUT samples at the posedge, results are checked at the negedge.
  task automatic step();
    @(posedge clk);
    cyc++;
    rst_seen = rst;
    @(negedge clk);
    monitor();
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    ifs.in_valid = v; ifs.in0 = a; ifs.in1 = b; ifs.in2 = c; ifs.in3 = d;
    ifu.in_valid = v; ifu.in0 = a; ifu.in1 = b; ifu.in2 = c; ifu.in3 = d;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
    exp_t e;
    int si, ui;
    drive(1'b1, a, b, c, d);
    if (!rst) begin
      si = int'(ref_idx(a, b, c, d, 1'b1));
      ui = int'(ref_idx(a, b, c, d, 1'b0));
      e.si = 2'(si);
      e.ui = 2'(ui);
      e.sd = (si == 0) ? a : (si == 1) ? b : (si == 2) ? c : d;
      e.ud = (ui == 0) ? a : (ui == 1) ? b : (ui == 2) ? c : d;
      e.due = cyc + LAT;
      sbq.push_back(e);
    end
    step();
  endtask

  task automatic idle();
    drive(1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 9'd5, 9'd6, 9'd7, 9'd8);
    repeat (3) send(9'd5, 9'd6, 9'd7, 9'd8);
    rst = 1'b0;
    send(9'd5, 9'd6, 9'd7, 9'd8);
    repeat (3) idle();

    // signed extremes, all-negative, tie patterns, unsigned top-bit case
    send(9'h100, 9'h1FF, 9'h0FF, 9'h000);
    send(9'h1FB, 9'h1FD, 9'h138, 9'h1FC);
    send(9'd7, 9'd7, 9'd7, 9'd7);
    send(9'd3, 9'd9, 9'd1, 9'd9);
    send(9'd2, 9'd1, 9'd4, 9'd4);
    send(9'h1FF, 9'h000, 9'h100, 9'h001);
    repeat (3) idle();

    // streaming: four back-to-back windows then idle
    vld_cnt = 0;
    send(9'd10, 9'd20, 9'd30, 9'd40);
    send(9'd44, 9'd3, 9'd2, 9'd1);
    send(9'd0, 9'd0, 9'd1, 9'd0);
    send(9'h1F0, 9'h0F0, 9'h0F1, 9'h0F0);
    repeat (4) idle();
    chk("stream_cnt", 32'(vld_cnt), 4);

    // mid-stream reset: in-flight windows must vanish
    send(9'd50, 9'd60, 9'd70, 9'd80);
    send(9'd90, 9'd11, 9'd12, 9'd13);
    rst = 1'b1;
    send(9'd1, 9'd2, 9'd3, 9'd4);
    rst = 1'b0;
    send(9'd33, 9'd99, 9'd22, 9'd11);
    repeat (3) idle();

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end
    repeat (4) idle();
    chk("drain", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max4_pool_unit.md
Name: max4_pool_unit

Overview:
- Four-input maximum selector for 2x2 max-pooling windows in the CNN digit-classification datapath.
- Receives the four window samples (row0 col n, row0 col n+1, row1 col n, row1 col n+1) from the pooling line buffer.
- Returns the largest value plus the index of the winning input.
- Registered outputs with a valid flag so the pooling controller can align its enable with the result.

Parameters:
- W, 9, sample width in bits (two's complement when SIGNED=1)
- SIGNED, 1, 1 = signed compare, 0 = unsigned compare

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in0..in3 hold a valid window this cycle
- in0  input  W  window element 0 (row0, col n)
- in1  input  W  window element 1 (row0, col n+1)
- in2  input  W  window element 2 (row1, col n)
- in3  input  W  window element 3 (row1, col n+1)
- dout  output  W  maximum of the accepted window (registered)
- max_idx  output  2  index 0..3 of the winning input (registered)
- out_valid  output  1  dout/max_idx valid this cycle

Behaviour:
- Reset:
  - Single clock clk; reset is synchronous and active-high on rst, sampled on the rising edge.
  - While rst=1: dout=0, max_idx=0, out_valid=0, all internal pipeline registers cleared.
  - Reset asserted mid-operation discards any in-flight window; no out_valid pulse for it after reset.
- Compare:
  - Signed when SIGNED=1, unsigned when SIGNED=0.
  - Full W-bit comparison; no truncation, saturation or sign extension of the output.
- Reduction tree:
  - Stage A: m01 = max(in0,in1) with idx01; m23 = max(in2,in3) with idx23.
  - Stage B: result = max(m01,m23).
- Tie-break:
  - On equality the lower index wins, at every comparison level.
  - Example: all four equal gives max_idx=0.
- Latency (default build): 1 cycle.
  - When in_valid=1 at edge k, dout, max_idx and out_valid=1 are presented after edge k.
  - They remain valid until the next edge.
- in_valid=0: out_valid=0 after the next edge; dout and max_idx hold their previous values.
- Back-to-back windows are accepted every cycle; no stall or backpressure input; throughput 1 window per clock.
- Inputs are sampled only when in_valid=1; X on inputs with in_valid=0 must not propagate to dout.
- No internal state beyond the pipeline registers.

Optional Feature:
- Macro MAX4A_PIPE_EN.
- When defined:
  - Stage A results (m01, m23, idx01, idx23) and a stage valid bit are registered.
  - Stage B compare is registered into the outputs.
  - Latency is 2 cycles, throughput still 1/clock.
  - rst clears both stages.
- When undefined:
  - Stage A and B are combinational into the single output register (latency 1).
- Output values, tie-break and reset behaviour are identical in both builds; only latency differs.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 and in0..3=5,6,7,8 -> dout=0, max_idx=0, out_valid=0 throughout; release -> first out_valid after configured latency with dout=8, max_idx=3.
- Signed mix (SIGNED=1, W=9): in0=-256, in1=-1, in2=255, in3=0 -> dout=255, max_idx=2. All negative -5,-3,-200,-4 -> dout=-3, max_idx=1.
- Ties: inputs 7,7,7,7 -> max_idx=0. Inputs 3,9,1,9 -> dout=9, max_idx=1. Inputs 2,1,4,4 -> max_idx=2.
- Unsigned build (SIGNED=0): in0=9'h1FF, in1=0, in2=9'h100, in3=1 -> dout=9'h1FF, max_idx=0.
- Streaming: 4 consecutive windows with in_valid=1 then in_valid=0 -> exactly 4 out_valid pulses in order with correct maxima; dout holds the last value after valid drops. Repeat with MAX4A_PIPE_EN and check a 2-cycle latency.
- Mid-stream reset: assert rst for 1 cycle while windows are in flight -> no out_valid for those windows; next window after release produces a correct result.
